// File: rtl/div_arbiter.sv
// Round-robin arbiter that lends one programmable clock divider to N_REQ requesters,
// holding each grant for a programmable number of divider output transitions.
module div_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] ratio,
    input  logic [7:0]          hold,
    input  logic                div_out,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic                busy,
    output logic [DW-1:0]       div_din,
    output logic                div_en,
    output logic                div_pl
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              prev_q, prev_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [DW-1:0]     din_q, din_d;
    logic              en_q, en_d;
    logic              pl_q, pl_d;

    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [DW-1:0]     sel_ratio;
    logic              trans;
    logic [CW:0]       hold_eff;
    logic              hit;

    // First pending requester strictly after rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!sel_found && req[IW'((32'(rr_ptr_q) + k) % N_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((32'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    assign sel_ratio = ratio[32'(sel_idx)*DW +: DW];
    assign trans     = div_out ^ prev_q;
    assign hold_eff  = (hold_q == '0) ? (CW+1)'(256) : {1'b0, hold_q};
    assign hit       = (({1'b0, cnt_q} + (CW+1)'(trans)) == hold_eff);

    // Next state and next registered outputs; outputs track the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        din_d    = din_q;
        en_d     = en_q;
        pl_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                en_d  = 1'b0;
                if (sel_found) begin
                    idx_d  = sel_idx;
                    hold_d = hold;
                    din_d  = sel_ratio;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (sel_ratio == '0) begin
                        state_d  = S_RELEASE;
                        err_d    = 1'b1;
                        done_d   = N_REQ'(1) << sel_idx;
                        rr_ptr_d = sel_idx;
                    end else begin
                        state_d = S_LOAD;
                        gnt_d   = N_REQ'(1) << sel_idx;
                        en_d    = 1'b1;
                        pl_d    = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Seed the edge detector so RUN entry never counts a transition.
                prev_d  = div_out;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d  = cnt_q + CW'(trans);
                prev_d = div_out;
                if (!req[idx_q] || hit) begin
                    state_d  = S_RELEASE;
                    gnt_d    = '0;
                    en_d     = 1'b0;
                    done_d   = N_REQ'(1) << idx_q;
                    rr_ptr_d = idx_q;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= IW'(N_REQ - 1);
            hold_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            din_q    <= '0;
            en_q     <= 1'b0;
            pl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            din_q    <= din_d;
            en_q     <= en_d;
            pl_q     <= pl_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign div_din = din_q;
    assign div_en  = en_q;
    assign div_pl  = pl_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: transaction-level reference model with randomized
// divider activity, checked cycle by cycle on the falling edge.
module tb_div_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] ratio;
    logic [7:0]      hold;
    logic            div_out;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            err;
    logic            busy;
    logic [DW-1:0]   div_din;
    logic            div_en;
    logic            div_pl;

    int n_checks = 0;
    int n_errors = 0;
    int last     = N - 1;

    div_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ratio   (ratio),
        .hold    (hold),
        .div_out (div_out),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .div_din (div_din),
        .div_en  (div_en),
        .div_pl  (div_pl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin choice: first requesting index after the last one served.
    function automatic int pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    // One full grant: request, load, run for the transitions, release, idle.
    task automatic do_grant(input logic [N-1:0] rq, input logic [N*DW-1:0] rt,
                            input logic [7:0] hd, input int abort_at, input bit keep_req,
                            input int pct, input bit scramble, output logic [N-1:0] g_obs);
        int            w;
        int            need;
        int            cnt;
        int            cyc;
        bit            fin;
        logic          prev;
        logic [N-1:0]  oh;
        logic [DW-1:0] r;
        w    = pick(rq, last);
        oh   = '0;
        oh[w] = 1'b1;
        r    = rt[w*DW +: DW];
        need = (hd == 8'd0) ? 256 : int'(hd);
        req   = rq;
        ratio = rt;
        hold  = hd;
        @(posedge clk); @(negedge clk);
        g_obs = gnt;
        if (r == '0) begin
            chk("zr_gnt", gnt, '0);
            chk("zr_err", err, 1);
            chk("zr_done", done, oh);
            chk("zr_en", div_en, 0);
            chk("zr_pl", div_pl, 0);
            chk("zr_busy", busy, 1);
            last = w;
            if (!keep_req) req = '0;
            @(posedge clk); @(negedge clk);
            chk("zr_idle_busy", busy, 0);
            chk("zr_idle_err", err, 0);
            chk("zr_idle_done", done, '0);
            chk("zr_idle_en", div_en, 0);
            return;
        end
        chk("ld_gnt", gnt, oh);
        chk("ld_busy", busy, 1);
        chk("ld_pl", div_pl, 1);
        chk("ld_en", div_en, 1);
        chk("ld_din", div_din, r);
        chk("ld_done", done, '0);
        chk("ld_err", err, 0);
        if ($urandom_range(99) < 32'(pct)) div_out = ~div_out;
        prev = div_out;
        if (scramble) begin
            ratio = {$urandom(), $urandom()};
            hold  = 8'($urandom());
        end
        cnt = 0;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            chk("run_gnt", gnt, oh);
            chk("run_en", div_en, 1);
            chk("run_pl", div_pl, 0);
            chk("run_din", div_din, r);
            chk("run_done", done, '0);
            if (cnt == abort_at) begin
                req[w] = 1'b0;
                fin    = 1'b1;
            end else begin
                if ($urandom_range(99) < 32'(pct)) div_out = ~div_out;
                if (div_out != prev) cnt++;
                prev = div_out;
                if (cnt == need) fin = 1'b1;
                if (scramble) begin
                    req   = (N'($urandom()) & ~oh) | oh;
                    ratio = {$urandom(), $urandom()};
                    hold  = 8'($urandom());
                end
            end
            if (cyc > 3000) begin
                n_checks++;
                n_errors++;
                $error("FAIL run_timeout: observed %0d cycles expected under 3000", cyc);
                fin = 1'b1;
            end
        end
        @(posedge clk); @(negedge clk);
        chk("rel_gnt", gnt, '0);
        chk("rel_en", div_en, 0);
        chk("rel_pl", div_pl, 0);
        chk("rel_done", done, oh);
        chk("rel_busy", busy, 1);
        chk("rel_err", err, 0);
        last = w;
        req  = keep_req ? rq : '0;
        @(posedge clk); @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, '0);
        chk("idle_gnt", gnt, '0);
        chk("idle_en", div_en, 0);
    endtask

    initial begin
        logic [N-1:0]    g;
        logic [N*DW-1:0] rt;
        logic [N-1:0]    rq;
        int              ab;
        int              hv;
        rst_n   = 1'b0;
        req     = '0;
        ratio   = '0;
        hold    = '0;
        div_out = 1'b0;
        #2;
        chk("rst_gnt", gnt, '0);
        chk("rst_done", done, '0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", div_din, '0);
        chk("rst_en", div_en, 0);
        chk("rst_pl", div_pl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting with hold=1: order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            rt = {16'd7, 16'd5, 16'd3, 16'd9};
            do_grant(4'b1111, rt, 8'd1, -1, i < 4, 70, 1'b0, g);
            chk("rr_order", g, 4'b0001 << (i % 4));
        end

        // Single request, ratio 2, hold 4, divider toggling every cycle.
        do_grant(4'b0001, {48'd0, 16'd2}, 8'd4, -1, 1'b0, 100, 1'b0, g);
        chk("single_gnt", g, 4'b0001);

        // Zero ratio is rejected with err and done.
        do_grant(4'b0010, {16'd4, 16'd4, 16'd0, 16'd4}, 8'd3, -1, 1'b0, 100, 1'b0, g);
        chk("zero_gnt", g, 4'b0000);

        // Abort after 2 of 5 transitions.
        do_grant(4'b0001, {48'd0, 16'd11}, 8'd5, 2, 1'b0, 100, 1'b0, g);

        // hold=0 means 256 transitions, with unrelated inputs churning.
        do_grant(4'b1000, {16'd300, 48'd0}, 8'd0, -1, 1'b0, 60, 1'b1, g);
        chk("hold0_gnt", g, 4'b1000);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            rq = N'($urandom_range(15, 1));
            for (int s = 0; s < N; s++) begin
                rt[s*DW +: DW] = ($urandom_range(4) == 0) ? DW'(0) : DW'($urandom_range(65535, 1));
            end
            hv = int'($urandom_range(6, 1));
            ab = ($urandom_range(9) < 3) ? int'($urandom_range(32'(hv - 1))) : -1;
            do_grant(rq, rt, 8'(hv), ab, 1'b0, int'($urandom_range(100, 40)), t[0], g);
        end

        // Asynchronous reset in the middle of RUN.
        req   = 4'b0001;
        ratio = {48'd0, 16'd3};
        hold  = 8'd50;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            div_out = ~div_out;
            @(posedge clk); @(negedge clk);
        end
        chk("pre_rst_en", div_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, '0);
        chk("arst_en", div_en, 0);
        chk("arst_done", done, '0);
        chk("arst_busy", busy, 0);
        chk("arst_pl", div_pl, 0);
        chk("arst_din", div_din, '0);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        last  = N - 1;
        @(negedge clk);
        do_grant(4'b0100, {16'd0, 16'd6, 32'd0}, 8'd3, -1, 1'b0, 80, 1'b0, g);
        chk("post_rst_gnt", g, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
